// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings and sizing helpers for the unified memory arbiter.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACC_I = 2'b01,
        ACC_D = 2'b10
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // The wait counter holds values up to LATENCY-1, but is never narrower than one bit.
    function automatic int cnt_w(input int latency);
        int w;
        w = $clog2(latency);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the unified memory arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the fetch/memory stages plus the memory macro.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IReq;
    logic [ADDR_W-1:0] IAddr;
    logic [DATA_W-1:0] IRdata;
    logic              IReady;
    logic              DReq;
    logic              DWe;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWdata;
    logic [DATA_W-1:0] DRdata;
    logic              DReady;
    logic              StallI;
    logic              StallD;
    logic              MemEn;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWdata;
    logic [DATA_W-1:0] MemRdata;

    modport slave (
        input  IReq, IAddr, DReq, DWe, DAddr, DWdata, MemRdata,
        output IRdata, IReady, DRdata, DReady, StallI, StallD,
               MemEn, MemWe, MemAddr, MemWdata
    );

    modport master (
        output IReq, IAddr, DReq, DWe, DAddr, DWdata, MemRdata,
        input  IRdata, IReady, DRdata, DReady, StallI, StallD,
               MemEn, MemWe, MemAddr, MemWdata
    );
endinterface

// File: rtl/unified_mem_arbiter_mem_wait_counter.sv
// Down-counter that times one fixed-latency memory access.
// load_i presets LATENCY-1; dec_i counts down to zero and stops there.
module mem_wait_counter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int  LATENCY = 2,
    localparam int CNT_W   = cnt_w(LATENCY)
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load wins over decrement, saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = LOAD_VAL;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - CNT_W'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port fixed-latency memory between the instruction
// fetch port (read-only) and the data port (read/write). Ties alternate,
// starting with the data port out of reset.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    unified_mem_arbiter_if.slave  bus
);
    // Masking instead of slicing keeps every address bit in use.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    arb_state_e        state_q, state_d;
    grant_e            last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] irdata_q, irdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic              iready_q, iready_d;
    logic              dready_q, dready_d;
    logic              load, done;
    logic              i_elig, d_elig;

    // A port whose Ready is high this cycle is holding its old request, not a new one.
    assign i_elig = bus.IReq & ~iready_q;
    assign d_elig = bus.DReq & ~dready_q;

    mem_wait_counter #(.LATENCY(LATENCY)) u_wait (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .dec_i  (state_q != IDLE),
        .done_o (done)
    );

    // Grant selection, request latching and completion handling.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        iready_d = 1'b0;
        dready_d = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_elig && (!i_elig || (last_q == GRANT_I))) begin
                    state_d = ACC_D;
                    last_d  = GRANT_D;
                    addr_d  = bus.DAddr & ALIGN_MASK;
                    we_d    = bus.DWe;
                    wdata_d = bus.DWdata;
                    load    = 1'b1;
                end else if (i_elig) begin
                    state_d = ACC_I;
                    last_d  = GRANT_I;
                    addr_d  = bus.IAddr & ALIGN_MASK;
                    we_d    = 1'b0;
                    load    = 1'b1;
                end
            end
            ACC_I: begin
                if (done) begin
                    irdata_d = bus.MemRdata;
                    iready_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            ACC_D: begin
                if (done) begin
                    if (!we_q) drdata_d = bus.MemRdata;
                    dready_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= GRANT_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Holding registers, captured read data and completion pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            iready_q <= 1'b0;
            dready_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            iready_q <= iready_d;
            dready_q <= dready_d;
        end
    end

    // The write strobe is confined to the last access cycle so the macro commits once.
    assign bus.MemEn    = (state_q != IDLE);
    assign bus.MemWe    = (state_q == ACC_D) & we_q & done;
    assign bus.MemAddr  = addr_q;
    assign bus.MemWdata = wdata_q;
    assign bus.IRdata   = irdata_q;
    assign bus.DRdata   = drdata_q;
    assign bus.IReady   = iready_q;
    assign bus.DReady   = dready_q;
    assign bus.StallI   = bus.IReq & ~iready_q;
    assign bus.StallD   = bus.DReq & ~dready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the shared memory.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
    localparam int LAT = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MWORDS = 1024;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

    unified_mem_arbiter #(.LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW)) u0 (
        .clk(clk), .reset(reset), .bus(if0));
    unified_mem_arbiter #(.LATENCY(1), .ADDR_W(AW), .DATA_W(DW)) u1 (
        .clk(clk), .reset(reset), .bus(if1));

    int n_tests = 0;
    int n_fail = 0;

    // Memory macro seen by u0, and the model's idea of its contents.
    logic [DW-1:0] mem [MWORDS];
    logic [DW-1:0] exp_mem [MWORDS];
    logic [DW-1:0] garb = '0;
    logic [DW-1:0] mem1_rdata = '0;

    // Transaction model: cycles left in the current access, owner, fairness bit.
    int            m_busy;
    logic          m_port;   // 0 = fetch, 1 = data
    logic          m_last;   // port granted last
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata, m_irdata, m_drdata;
    logic          m_ir, m_dr;

    // Memory data is only meaningful in the last access cycle; junk otherwise.
    assign if0.MemRdata = (m_busy == 1) ? mem[if0.MemAddr[11:2]] : garb;
    assign if1.MemRdata = mem1_rdata;

    always @(posedge clk) if (if0.MemWe) mem[if0.MemAddr[11:2]] <= if0.MemWdata;

    function automatic void model_reset();
        m_busy = 0; m_port = 1'b0; m_last = 1'b0; m_addr = '0; m_we = 1'b0;
        m_wdata = '0; m_irdata = '0; m_drdata = '0; m_ir = 1'b0; m_dr = 1'b0;
    endfunction

    // One clock edge of the shared memory: finish the access or pick a requester.
    function automatic void model_step(logic ireq, logic dreq, logic [AW-1:0] ia,
                                       logic [AW-1:0] da, logic dwe, logic [DW-1:0] dwd);
        logic nir, ndr, ei, ed;
        int idx;
        nir = 1'b0; ndr = 1'b0;
        if (m_busy > 0) begin
            idx = int'(m_addr[11:2]);
            if (m_busy == 1) begin
                if (!m_port) begin m_irdata = exp_mem[idx]; nir = 1'b1; end
                else begin
                    if (m_we) exp_mem[idx] = m_wdata; else m_drdata = exp_mem[idx];
                    ndr = 1'b1;
                end
            end
            m_busy = m_busy - 1;
        end else begin
            ei = ireq && !m_ir;
            ed = dreq && !m_dr;
            if (ed && (!ei || !m_last)) begin
                m_port = 1'b1; m_last = 1'b1; m_addr = da & ~32'h3;
                m_we = dwe; m_wdata = dwd; m_busy = LAT;
            end else if (ei) begin
                m_port = 1'b0; m_last = 1'b0; m_addr = ia & ~32'h3;
                m_we = 1'b0; m_busy = LAT;
            end
        end
        m_ir = nir; m_dr = ndr;
    endfunction

    // Advance one cycle; returns at the following falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) model_reset();
        else model_step(if0.IReq, if0.DReq, if0.IAddr, if0.DAddr, if0.DWe, if0.DWdata);
        garb = $urandom;
        @(negedge clk);
    endtask

    task automatic preload(int idx, logic [DW-1:0] v);
        mem[idx] <= v;
        exp_mem[idx] = v;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        for (int i = 0; i < MWORDS; i++) begin v = $urandom; preload(i, v); end
        {if0.IReq, if0.DReq, if0.DWe, if1.IReq, if1.DReq, if1.DWe} = '0;
        {if0.IAddr, if0.DAddr, if0.DWdata, if1.IAddr, if1.DAddr, if1.DWdata} = '0;
        model_reset();
        reset = 1'b0;
        if0.IReq = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({if0.IRdata, if0.DRdata, if0.IReady, if0.DReady, if0.MemEn, if0.MemWe,
             if0.MemAddr, if0.MemWdata} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got en=%b we=%b addr=%h ir=%h dr=%h want all 0",
                               if0.MemEn, if0.MemWe, if0.MemAddr, if0.IRdata, if0.DRdata);
        end
        n_tests++;
        if (if0.StallI !== 1'b1 || if0.StallD !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall got I=%b D=%b want I=1 D=0", if0.StallI, if0.StallD);
        end
        n_tests++;
        if (if1.MemEn !== 1'b0 || if1.DReady !== 1'b0) begin
            n_fail++; $display("FAIL reset_lat1 got en=%b drdy=%b want 0 0", if1.MemEn, if1.DReady);
        end
        if0.IReq = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_ifetch();
        logic en_w, rdy_w;
        preload(32'h40 >> 2, 32'h8C01_0004);
        if0.IReq = 1'b1; if0.IAddr = 32'h40;
        for (int k = 0; k <= 4; k++) begin
            if (k == 4) if0.IReq = 1'b0;
            #1;
            en_w = (k == 1 || k == 2); rdy_w = (k == 3);
            n_tests++;
            if (if0.MemEn !== en_w) begin n_fail++; $display("FAIL ifetch_memen k=%0d got %b want %b", k, if0.MemEn, en_w); end
            n_tests++;
            if (if0.IReady !== rdy_w) begin n_fail++; $display("FAIL ifetch_ready k=%0d got %b want %b", k, if0.IReady, rdy_w); end
            n_tests++;
            if (if0.StallI !== (k < 3)) begin n_fail++; $display("FAIL ifetch_stall k=%0d got %b want %b", k, if0.StallI, k < 3); end
            if (en_w) begin
                n_tests++;
                if (if0.MemAddr !== 32'h40) begin n_fail++; $display("FAIL ifetch_addr k=%0d got %h want 00000040", k, if0.MemAddr); end
            end
            if (rdy_w) begin
                n_tests++;
                if (if0.IRdata !== 32'h8C01_0004) begin n_fail++; $display("FAIL ifetch_data got %h want 8c010004", if0.IRdata); end
            end
            tick();
        end
    endtask

    task automatic test_dwrite();
        logic en_w;
        if0.DReq = 1'b1; if0.DWe = 1'b1; if0.DAddr = 32'h103; if0.DWdata = 32'hDEAD_BEEF;
        for (int k = 0; k <= 4; k++) begin
            if (k == 4) begin if0.DReq = 1'b0; if0.DWe = 1'b0; end
            #1;
            en_w = (k == 1 || k == 2);
            n_tests++;
            if (if0.MemEn !== en_w) begin n_fail++; $display("FAIL dwrite_memen k=%0d got %b want %b", k, if0.MemEn, en_w); end
            n_tests++;
            if (if0.MemWe !== (k == 2)) begin n_fail++; $display("FAIL dwrite_memwe k=%0d got %b want %b", k, if0.MemWe, k == 2); end
            n_tests++;
            if (if0.DReady !== (k == 3)) begin n_fail++; $display("FAIL dwrite_ready k=%0d got %b want %b", k, if0.DReady, k == 3); end
            if (en_w) begin
                n_tests++;
                if (if0.MemAddr !== 32'h100) begin n_fail++; $display("FAIL dwrite_addr k=%0d got %h want 00000100", k, if0.MemAddr); end
            end
            if (k == 2) begin
                n_tests++;
                if (if0.MemWdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dwrite_wdata got %h want deadbeef", if0.MemWdata); end
            end
            if (k == 3) begin
                n_tests++;
                if (if0.DRdata !== 32'h0) begin n_fail++; $display("FAIL dwrite_drdata got %h want 00000000", if0.DRdata); end
            end
            tick();
        end
        n_tests++;
        if (mem[32'h100 >> 2] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dwrite_commit got %h want deadbeef", mem[32'h100 >> 2]); end
    endtask

    task automatic test_tie();
        logic en_w, ir_w, dr_w;
        do_reset();
        preload(32'h200 >> 2, 32'h1111_2222);
        preload(32'h300 >> 2, 32'h3333_4444);
        if0.IReq = 1'b1; if0.IAddr = 32'h300;
        if0.DReq = 1'b1; if0.DWe = 1'b0; if0.DAddr = 32'h200;
        for (int k = 0; k <= 16; k++) begin
            if (k == 13) begin if0.IReq = 1'b0; if0.DReq = 1'b0; end
            #1;
            dr_w = (k == 3 || k == 9 || k == 15);
            ir_w = (k == 6 || k == 12);
            en_w = (k % 3 != 0) && (k < 15);
            n_tests++;
            if (if0.DReady !== dr_w) begin n_fail++; $display("FAIL tie_dready k=%0d got %b want %b", k, if0.DReady, dr_w); end
            n_tests++;
            if (if0.IReady !== ir_w) begin n_fail++; $display("FAIL tie_iready k=%0d got %b want %b", k, if0.IReady, ir_w); end
            n_tests++;
            if (if0.MemEn !== en_w) begin n_fail++; $display("FAIL tie_memen k=%0d got %b want %b", k, if0.MemEn, en_w); end
            if (dr_w) begin
                n_tests++;
                if (if0.DRdata !== 32'h1111_2222) begin n_fail++; $display("FAIL tie_ddata k=%0d got %h want 11112222", k, if0.DRdata); end
            end
            if (ir_w) begin
                n_tests++;
                if (if0.IRdata !== 32'h3333_4444) begin n_fail++; $display("FAIL tie_idata k=%0d got %h want 33334444", k, if0.IRdata); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        preload(32'h500 >> 2, 32'h0BAD_BEEF);
        if0.DReq = 1'b1; if0.DWe = 1'b1; if0.DAddr = 32'h500; if0.DWdata = 32'hCAFE_F00D;
        tick();
        #1;
        n_tests++;
        if (if0.MemEn !== 1'b1) begin n_fail++; $display("FAIL abort_started got en=%b want 1", if0.MemEn); end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({if0.IRdata, if0.DRdata, if0.IReady, if0.DReady, if0.MemEn, if0.MemWe,
             if0.MemAddr, if0.MemWdata} !== '0) begin
            n_fail++; $display("FAIL abort_outputs got en=%b we=%b addr=%h dr=%h want all 0",
                               if0.MemEn, if0.MemWe, if0.MemAddr, if0.DRdata);
        end
        if0.DReq = 1'b0; if0.DWe = 1'b0;
        tick(); tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++;
            if (if0.DReady !== 1'b0 || if0.MemEn !== 1'b0) begin
                n_fail++; $display("FAIL abort_quiet k=%0d got drdy=%b en=%b want 0 0", k, if0.DReady, if0.MemEn);
            end
            tick();
        end
        n_tests++;
        if (mem[32'h500 >> 2] !== 32'h0BAD_BEEF) begin n_fail++; $display("FAIL abort_nowrite got %h want 0badbeef", mem[32'h500 >> 2]); end
        if0.IReq = 1'b1; if0.IAddr = 32'h40;
        for (int k = 0; k <= 4; k++) begin
            if (k == 4) if0.IReq = 1'b0;
            #1;
            n_tests++;
            if (if0.IReady !== (k == 3)) begin n_fail++; $display("FAIL abort_refetch_ready k=%0d got %b want %b", k, if0.IReady, k == 3); end
            if (k == 3) begin
                n_tests++;
                if (if0.IRdata !== 32'h8C01_0004) begin n_fail++; $display("FAIL abort_refetch_data got %h want 8c010004", if0.IRdata); end
            end
            tick();
        end
    endtask

    task automatic test_lat1();
        mem1_rdata = 32'h5;
        for (int op = 0; op < 2; op++) begin
            if1.DReq = 1'b1; if1.DWe = (op == 1);
            if1.DAddr = (op == 0) ? 32'h8 : 32'hC; if1.DWdata = 32'h77;
            for (int k = 0; k <= 3; k++) begin
                if (k == 3) begin if1.DReq = 1'b0; if1.DWe = 1'b0; end
                #1;
                n_tests++;
                if (if1.MemEn !== (k == 1)) begin n_fail++; $display("FAIL lat1_memen op=%0d k=%0d got %b want %b", op, k, if1.MemEn, k == 1); end
                n_tests++;
                if (if1.MemWe !== (k == 1 && op == 1)) begin n_fail++; $display("FAIL lat1_memwe op=%0d k=%0d got %b want %b", op, k, if1.MemWe, k == 1 && op == 1); end
                n_tests++;
                if (if1.DReady !== (k == 2)) begin n_fail++; $display("FAIL lat1_ready op=%0d k=%0d got %b want %b", op, k, if1.DReady, k == 2); end
                if (k == 1) begin
                    n_tests++;
                    if (if1.MemAddr !== ((op == 0) ? 32'h8 : 32'hC)) begin n_fail++; $display("FAIL lat1_addr op=%0d got %h", op, if1.MemAddr); end
                end
                if (k == 1 && op == 1) begin
                    n_tests++;
                    if (if1.MemWdata !== 32'h77) begin n_fail++; $display("FAIL lat1_wdata got %h want 00000077", if1.MemWdata); end
                end
                if (k == 2) begin
                    n_tests++;
                    if (if1.DRdata !== 32'h5) begin n_fail++; $display("FAIL lat1_drdata op=%0d got %h want 00000005", op, if1.DRdata); end
                end
                tick();
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (!if0.IReq) begin
                if ($urandom_range(0, 2) == 0) begin if0.IReq = 1'b1; if0.IAddr = $urandom_range(0, 4095); end
            end else if (m_ir) begin
                if ($urandom_range(0, 1) == 0) if0.IReq = 1'b0; else if0.IAddr = $urandom_range(0, 4095);
            end else if ($urandom_range(0, 15) == 0) if0.IAddr = $urandom_range(0, 4095);
            if (!if0.DReq) begin
                if ($urandom_range(0, 2) == 0) begin
                    if0.DReq = 1'b1; if0.DWe = $urandom_range(0, 1);
                    if0.DAddr = $urandom_range(0, 4095); if0.DWdata = $urandom;
                end
            end else if (m_dr) begin
                if ($urandom_range(0, 1) == 0) if0.DReq = 1'b0;
                else begin if0.DWe = $urandom_range(0, 1); if0.DAddr = $urandom_range(0, 4095); if0.DWdata = $urandom; end
            end else if ($urandom_range(0, 15) == 0) begin
                if0.DAddr = $urandom_range(0, 4095); if0.DWdata = $urandom;
            end
            #1;
            n_tests++;
            if (if0.IReady !== m_ir || if0.DReady !== m_dr) begin
                n_fail++; $display("FAIL rand_ready c=%0d got I=%b D=%b want I=%b D=%b", c, if0.IReady, if0.DReady, m_ir, m_dr);
            end
            n_tests++;
            if (if0.MemEn !== (m_busy > 0) || if0.MemWe !== (m_busy == 1 && m_port && m_we)) begin
                n_fail++; $display("FAIL rand_mem_ctl c=%0d got en=%b we=%b want en=%b we=%b", c, if0.MemEn, if0.MemWe,
                                   m_busy > 0, m_busy == 1 && m_port && m_we);
            end
            if (m_busy > 0) begin
                n_tests++;
                if (if0.MemAddr !== m_addr) begin n_fail++; $display("FAIL rand_addr c=%0d got %h want %h", c, if0.MemAddr, m_addr); end
            end
            if (m_busy == 1 && m_port && m_we) begin
                n_tests++;
                if (if0.MemWdata !== m_wdata) begin n_fail++; $display("FAIL rand_wdata c=%0d got %h want %h", c, if0.MemWdata, m_wdata); end
            end
            n_tests++;
            if (if0.IRdata !== m_irdata || if0.DRdata !== m_drdata) begin
                n_fail++; $display("FAIL rand_rdata c=%0d got I=%h D=%h want I=%h D=%h", c, if0.IRdata, if0.DRdata, m_irdata, m_drdata);
            end
            n_tests++;
            if (if0.StallI !== (if0.IReq && !m_ir) || if0.StallD !== (if0.DReq && !m_dr)) begin
                n_fail++; $display("FAIL rand_stall c=%0d got I=%b D=%b want I=%b D=%b", c, if0.StallI, if0.StallD,
                                   if0.IReq && !m_ir, if0.DReq && !m_dr);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_dwrite();
        test_tie();
        test_reset_mid();
        test_lat1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port (read-only) and its data-memory port (read/write). A three-state FSM grants the memory, holds address and data stable for LATENCY cycles, captures read data and pulses a per-port ready. It drives the stall requests the pipeline needs while its access is outstanding, and it sits between the fetch/memory stages and the memory macro.

Parameters:
LATENCY, 2, memory access cycles per transaction (legal range >=1)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
IReq  in  1  fetch read request; held until IReady
IAddr  in  ADDR_W  fetch byte address
IRdata  out  DATA_W  fetch read data, valid when IReady=1
IReady  out  1  one-cycle fetch completion pulse
DReq  in  1  data request; held until DReady
DWe  in  1  1=write, 0=read; qualified by DReq
DAddr  in  ADDR_W  data byte address
DWdata  in  DATA_W  write data
DRdata  out  DATA_W  data read data, valid when DReady=1
DReady  out  1  one-cycle data completion pulse
StallI  out  1  IReq & ~IReady (combinational)
StallD  out  1  DReq & ~DReady (combinational)
MemEn  out  1  memory enable
MemWe  out  1  memory write strobe
MemAddr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
MemWdata  out  DATA_W  memory write data
MemRdata  in  DATA_W  memory read data; valid in the last access cycle

Behaviour:
- Reset (async, reset=0): state=IDLE, counter=0, LastGrant=I. All outputs are 0: IRdata, DRdata, IReady, DReady, MemEn, MemWe, MemAddr, MemWdata. StallI/StallD follow their equations.
- States are IDLE, ACC_I and ACC_D.
- IDLE: the eligible requests are IReq&~IReady and DReq&~DReady. A port whose Ready is high this cycle is masked for this cycle, so a held Req is not seen as a new request.
  - Only D eligible: next state ACC_D.
  - Only I eligible: next state ACC_I.
  - Both eligible: grant the port not equal to LastGrant. LastGrant resets to I, so D wins the first tie.
  - On a grant, latch address, DWe and DWdata into holding registers, set counter=LATENCY-1 and update LastGrant.
- ACC_x:
  - MemEn=1; MemAddr and MemWdata come from the holding registers and stay stable for all LATENCY cycles.
  - MemWe=1 only in the final cycle (counter==0) of a D write.
  - The counter decrements each cycle.
  - At counter==0, the read data is captured (see below), the port's Ready is set for the next cycle, and the next state is IDLE.
- Read data capture at counter==0: for reads, IRdata or DRdata <= MemRdata. For a write, DRdata is unchanged.
- Latency: Req is sampled in IDLE at edge t. Access occupies cycles t+1..t+LATENCY. Ready is high in cycle t+LATENCY+1, which is an IDLE cycle.
- Throughput: at least one IDLE cycle separates transactions, so peak throughput is one transaction per LATENCY+1 cycles.
- IRdata and DRdata hold their last value until the next read on that port completes.
- Req or address changes during ACC are ignored; the latched values are used. A Req dropped mid-access still completes, and Ready still pulses.
- Reset asserted mid-access aborts immediately: MemEn and MemWe go to 0 asynchronously, no Ready is issued and no write is committed.
- With LATENCY=1, ACC lasts a single cycle, and MemWe is high in that cycle for writes.
- MemAddr bits [1:0] are always 0. Width mismatches are truncated or zero-extended to ADDR_W.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, ACC_I=2'b01, ACC_D=2'b10), grant encoding (GRANT_I=0, GRANT_D=1) and counter width CNT_W=max(1,clog2(LATENCY)).
- Sub-module: mem_wait_counter. It loads LATENCY-1, decrements, and outputs done=(cnt==0). It uses the same clk and reset.

Test Plan:
- LATENCY=2; IReq=1, IAddr=0x40, MemRdata=0x8C010004 in the final access cycle -> MemEn high 2 cycles with MemAddr=0x40, then IReady pulses 1 cycle (3 cycles after sampling) with IRdata=0x8C010004; StallI=1 until then.
- DReq=1, DWe=1, DAddr=0x103, DWdata=0xDEADBEEF -> MemAddr=0x100, MemWe=1 only in the 2nd access cycle, DReady pulses, DRdata unchanged.
- IReq and DReq rise together from reset -> D is served first (ready at cycle 3), then I (ready at cycle 6). Repeat with both still requesting -> grants alternate I, D.
- Req held high through its Ready cycle -> no duplicate transaction; IDLE lasts one cycle, then the other pending port or nothing is granted.
- Reset pulled low in the 1st access cycle of a D write -> MemEn and MemWe fall immediately, no DReady, outputs are 0; after release, a new IReq completes normally.
- LATENCY=1 build; DReq read at 0x8, MemRdata=0x5 -> MemEn for 1 cycle, DReady 2 cycles after sampling with DRdata=0x5.
